// File: rtl/dcache_mshr.sv
// Data-cache miss-status holding registers: allocates and merges misses per 8-byte block,
// issues one memory LOAD per cycle, tracks memory tags and returns fills as registered packets.
module dcache_mshr #(
    parameter int  MSHR_SZ = 4,
    localparam int IW      = $clog2(MSHR_SZ)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          alloc_valid,
    input  logic [31:0]   alloc_addr,
    output logic          alloc_gnt,
    output logic [IW-1:0] alloc_idx,
    output logic          alloc_merge,
    output logic          mshr_full,
    input  logic          mem_gnt,
    output logic [1:0]    proc2mem_command,
    output logic [31:0]   proc2mem_addr,
    input  logic [3:0]    mem2proc_transaction_tag,
    input  logic [3:0]    mem2proc_data_tag,
    input  logic [63:0]   mem2proc_data,
    output logic          fill_valid,
    output logic [IW-1:0] fill_idx,
    output logic [31:0]   fill_addr,
    output logic [63:0]   fill_data
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_WAITING = 2'd2
    } state_e;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    state_e        r_state [MSHR_SZ];
    logic [28:0]   r_addr  [MSHR_SZ];
    logic [3:0]    r_tag   [MSHR_SZ];

    logic          r_fill_valid;
    logic [IW-1:0] r_fill_idx;
    logic [31:0]   r_fill_addr;
    logic [63:0]   r_fill_data;

    logic [MSHR_SZ-1:0] w_free_vec;
    logic [MSHR_SZ-1:0] w_pend_vec;
    logic [MSHR_SZ-1:0] w_fill_vec;
    logic [MSHR_SZ-1:0] w_match_vec;
    logic               w_fill_any;
    logic [IW-1:0]      w_fill_idx;
    logic               w_fill_conflict;
    logic               w_match_any;
    logic               w_free_any;
    logic               w_alloc_new;
    logic [IW-1:0]      w_free_idx;
    logic               w_issue_any;
    logic [IW-1:0]      w_issue_idx;
    logic               w_issue_accept;
    logic [31:0]        w_alloc_aligned;

    // Lowest set bit of a request vector; zero when the vector is empty.
    function automatic logic [IW-1:0] f_lowest(input logic [MSHR_SZ-1:0] vec);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = MSHR_SZ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign w_alloc_aligned = alloc_addr & 32'hFFFF_FFF8;

    // Per-entry status vectors: free, pending, tag hit for this cycle's data, block match for the alloc.
    always_comb begin
        w_free_vec  = '0;
        w_pend_vec  = '0;
        w_fill_vec  = '0;
        w_match_vec = '0;
        for (int i = 0; i < MSHR_SZ; i++) begin
            w_free_vec[i]  = (r_state[i] == ST_FREE);
            w_pend_vec[i]  = (r_state[i] == ST_PENDING);
            w_fill_vec[i]  = (r_state[i] == ST_WAITING) && (mem2proc_data_tag != 4'd0)
                             && (r_tag[i] == mem2proc_data_tag);
            w_match_vec[i] = (r_state[i] != ST_FREE) && ({r_addr[i], 3'b000} == w_alloc_aligned);
        end
    end

    assign w_fill_any  = |w_fill_vec;
    assign w_fill_idx  = f_lowest(w_fill_vec);
    assign w_match_any = |w_match_vec;
    assign w_free_any  = |w_free_vec;
    assign w_free_idx  = f_lowest(w_free_vec);

    // The block being filled this cycle is refused; the requester will hit the cache on retry.
    assign w_fill_conflict = |(w_fill_vec & w_match_vec);

    assign alloc_gnt   = alloc_valid && !w_fill_conflict && (w_match_any || w_free_any);
    assign alloc_merge = alloc_valid && !w_fill_conflict && w_match_any;
    assign alloc_idx   = w_match_any ? f_lowest(w_match_vec) : w_free_idx;
    assign w_alloc_new = alloc_gnt && !w_match_any;
    assign mshr_full   = !w_free_any;

    assign w_issue_any      = |w_pend_vec;
    assign w_issue_idx      = f_lowest(w_pend_vec);
    assign proc2mem_command = w_issue_any ? CMD_LOAD : CMD_NONE;
    assign proc2mem_addr    = w_issue_any ? {r_addr[w_issue_idx], 3'b000} : 32'd0;
    assign w_issue_accept   = w_issue_any && mem_gnt && (mem2proc_transaction_tag != 4'd0);

    // Entry state machine; alloc, issue and fill always target distinct entries by state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSHR_SZ; i++) begin
                r_state[i] <= ST_FREE;
                r_addr[i]  <= 29'd0;
                r_tag[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < MSHR_SZ; i++) begin
                if (w_alloc_new && (w_free_idx == IW'(i))) begin
                    r_state[i] <= ST_PENDING;
                    r_addr[i]  <= w_alloc_aligned[31:3];
                    r_tag[i]   <= 4'd0;
                end else if (w_issue_accept && (w_issue_idx == IW'(i))) begin
                    r_state[i] <= ST_WAITING;
                    r_tag[i]   <= mem2proc_transaction_tag;
                end else if (w_fill_any && (w_fill_idx == IW'(i))) begin
                    r_state[i] <= ST_FREE;
                    r_tag[i]   <= 4'd0;
                end else begin
                    r_state[i] <= r_state[i];
                end
            end
        end
    end

    // Fill packet register: strobe lasts one cycle, payload holds until the next fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fill_valid <= 1'b0;
            r_fill_idx   <= '0;
            r_fill_addr  <= 32'd0;
            r_fill_data  <= 64'd0;
        end else begin
            r_fill_valid <= w_fill_any;
            if (w_fill_any) begin
                r_fill_idx  <= w_fill_idx;
                r_fill_addr <= {r_addr[w_fill_idx], 3'b000};
                r_fill_data <= mem2proc_data;
            end else begin
                r_fill_idx  <= r_fill_idx;
                r_fill_addr <= r_fill_addr;
                r_fill_data <= r_fill_data;
            end
        end
    end

    assign fill_valid = r_fill_valid;
    assign fill_idx   = r_fill_idx;
    assign fill_addr  = r_fill_addr;
    assign fill_data  = r_fill_data;

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed bench for dcache_mshr: fills are scoreboarded through a queue of expected packets.
module tb_dcache_mshr;

    logic        clock = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [31:0] alloc_addr;
    logic        alloc_gnt;
    logic [1:0]  alloc_idx;
    logic        alloc_merge;
    logic        mshr_full;
    logic        mem_gnt;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_transaction_tag;
    logic [3:0]  mem2proc_data_tag;
    logic [63:0] mem2proc_data;
    logic        fill_valid;
    logic [1:0]  fill_idx;
    logic [31:0] fill_addr;
    logic [63:0] fill_data;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] addr;
        logic [63:0] data;
    } fill_t;

    fill_t exp_q[$];
    fill_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    dcache_mshr #(.MSHR_SZ(4)) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .alloc_merge(alloc_merge),
        .mshr_full(mshr_full), .mem_gnt(mem_gnt),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data_tag(mem2proc_data_tag), .mem2proc_data(mem2proc_data),
        .fill_valid(fill_valid), .fill_idx(fill_idx),
        .fill_addr(fill_addr), .fill_data(fill_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_valid              = 1'b0;
        alloc_addr               = 32'd0;
        mem_gnt                  = 1'b0;
        mem2proc_transaction_tag = 4'd0;
        mem2proc_data_tag        = 4'd0;
        mem2proc_data            = 64'd0;
    endtask

    task automatic alloc(input logic [31:0] a);
        alloc_valid = 1'b1;
        alloc_addr  = a;
    endtask

    task automatic data(input logic [3:0] tag, input logic [63:0] d);
        mem2proc_data_tag = tag;
        mem2proc_data     = d;
    endtask

    task automatic expect_fill(input logic [1:0] idx, input logic [31:0] a, input logic [63:0] d);
        fill_t f;
        f.idx  = idx;
        f.addr = a;
        f.data = d;
        exp_q.push_back(f);
    endtask

    // Fill monitor: every strobe must match the oldest expected packet.
    always @(negedge clock) begin
        if (fill_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL fill_unexpected observed idx=%0d addr=%h expected none", fill_idx, fill_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fill_idx", 64'(fill_idx), 64'(mon_e.idx));
                chk("fill_addr", 64'(fill_addr), 64'(mon_e.addr));
                chk("fill_data", fill_data, mon_e.data);
            end
        end
    end

    // At most one live entry per block address.
    always @(negedge clock) begin
        logic dup;
        if (reset === 1'b1) begin
            dup = 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = i + 1; j < 4; j++) begin
                    if ((dut.r_state[i] != 2'd0) && (dut.r_state[j] != 2'd0)
                        && (dut.r_addr[i] == dut.r_addr[j])) begin
                        dup = 1'b1;
                    end
                end
            end
            chk("block_unique", 64'(dup), 64'd0);
        end
    end

    initial begin
        reset = 1'b0;
        idle();
        #2;
        chk("rst_alloc_gnt", 64'(alloc_gnt), 64'd0);
        chk("rst_mshr_full", 64'(mshr_full), 64'd0);
        chk("rst_cmd", 64'(proc2mem_command), 64'd0);
        chk("rst_mem_addr", 64'(proc2mem_addr), 64'd0);
        chk("rst_fill_valid", 64'(fill_valid), 64'd0);
        chk("rst_fill_idx", 64'(fill_idx), 64'd0);
        chk("rst_fill_addr", 64'(fill_addr), 64'd0);
        chk("rst_fill_data", fill_data, 64'd0);
        #10 reset = 1'b1;

        // Single miss
        tick(); idle(); alloc(32'h0000_1004); #1;
        chk("t1_gnt", 64'(alloc_gnt), 64'd1);
        chk("t1_idx", 64'(alloc_idx), 64'd0);
        chk("t1_merge", 64'(alloc_merge), 64'd0);
        chk("t1_no_issue_c0", 64'(proc2mem_command), 64'd0);
        tick(); idle(); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd3; #1;
        chk("t1_cmd", 64'(proc2mem_command), 64'd1);
        chk("t1_addr", 64'(proc2mem_addr), 64'h1000);
        tick(); idle(); #1;
        chk("t1_waiting", 64'(proc2mem_command), 64'd0);
        tick(); idle();
        tick(); idle();
        tick(); idle(); data(4'd3, 64'hAAAA_BBBB_CCCC_DDDD);
        expect_fill(2'd0, 32'h1000, 64'hAAAA_BBBB_CCCC_DDDD);
        tick(); idle(); #1;
        chk("t1_fill_strobe", 64'(fill_valid), 64'd1);
        tick(); idle(); #1;
        chk("t1_fill_one_cycle", 64'(fill_valid), 64'd0);

        // Merge
        tick(); idle(); alloc(32'h0000_2000); #1;
        chk("t2_gnt0", 64'(alloc_gnt), 64'd1);
        chk("t2_idx0", 64'(alloc_idx), 64'd0);
        tick(); idle(); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd4; #1;
        chk("t2_cmd", 64'(proc2mem_command), 64'd1);
        chk("t2_addr", 64'(proc2mem_addr), 64'h2000);
        tick(); idle(); alloc(32'h0000_2004); #1;
        chk("t2_merge_gnt", 64'(alloc_gnt), 64'd1);
        chk("t2_merge", 64'(alloc_merge), 64'd1);
        chk("t2_merge_idx", 64'(alloc_idx), 64'd0);
        chk("t2_no_reissue", 64'(proc2mem_command), 64'd0);
        tick(); idle(); #1;
        chk("t2_no_reissue2", 64'(proc2mem_command), 64'd0);
        data(4'd4, 64'h0123_4567_89AB_CDEF);
        expect_fill(2'd0, 32'h2000, 64'h0123_4567_89AB_CDEF);
        tick(); idle();
        tick(); idle();

        // Full
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'h4000 + 32'(k * 8);
            alloc(a); #1;
            chk("t3_gnt", 64'(alloc_gnt), 64'd1);
            chk("t3_idx", 64'(alloc_idx), 64'(k));
            tick(); idle();
        end
        alloc(32'h0000_5000); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd1; #1;
        chk("t3_full", 64'(mshr_full), 64'd1);
        chk("t3_fifth_gnt", 64'(alloc_gnt), 64'd0);
        chk("t3_issue0", 64'(proc2mem_addr), 64'h4000);
        tick(); idle(); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd2; #1;
        chk("t3_issue1", 64'(proc2mem_addr), 64'h4008);
        tick(); idle(); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd6; #1;
        chk("t3_issue2", 64'(proc2mem_addr), 64'h4010);
        tick(); idle(); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd7; #1;
        chk("t3_issue3", 64'(proc2mem_addr), 64'h4018);
        tick(); idle(); alloc(32'h0000_5000); data(4'd6, 64'h6666_0000_6666_0000); #1;
        expect_fill(2'd2, 32'h4010, 64'h6666_0000_6666_0000);
        chk("t3_all_waiting", 64'(proc2mem_command), 64'd0);
        chk("t3_full_during_fill", 64'(mshr_full), 64'd1);
        chk("t3_no_reuse_same_cycle", 64'(alloc_gnt), 64'd0);
        tick(); idle(); alloc(32'h0000_5000); #1;
        chk("t3_reuse_gnt", 64'(alloc_gnt), 64'd1);
        chk("t3_reuse_idx", 64'(alloc_idx), 64'd2);
        chk("t3_reuse_merge", 64'(alloc_merge), 64'd0);
        chk("t3_not_full", 64'(mshr_full), 64'd0);
        tick(); idle(); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd8;
        data(4'd1, 64'h1111_1111_1111_1111); #1;
        expect_fill(2'd0, 32'h4000, 64'h1111_1111_1111_1111);
        chk("t3_issue_new", 64'(proc2mem_addr), 64'h5000);
        tick(); idle(); data(4'd2, 64'h2222_2222_2222_2222);
        expect_fill(2'd1, 32'h4008, 64'h2222_2222_2222_2222);
        tick(); idle(); data(4'd7, 64'h7777_7777_7777_7777);
        expect_fill(2'd3, 32'h4018, 64'h7777_7777_7777_7777);
        tick(); idle(); data(4'd8, 64'h8888_8888_8888_8888);
        expect_fill(2'd2, 32'h5000, 64'h8888_8888_8888_8888);
        tick(); idle();
        tick(); idle();

        // Tag retry and unmatched data tag
        alloc(32'h0000_6000); #1;
        chk("t4_idx", 64'(alloc_idx), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); idle(); mem_gnt = 1'b1;
            mem2proc_transaction_tag = (k == 2) ? 4'd5 : 4'd0; #1;
            chk("t4_held_cmd", 64'(proc2mem_command), 64'd1);
            chk("t4_held_addr", 64'(proc2mem_addr), 64'h6000);
        end
        tick(); idle(); data(4'd9, 64'h9999_9999_9999_9999); #1;
        chk("t4_waiting", 64'(proc2mem_command), 64'd0);
        tick(); idle(); data(4'd5, 64'h5555_5555_5555_5555); #1;
        expect_fill(2'd0, 32'h6000, 64'h5555_5555_5555_5555);
        chk("t4_no_fill_tag9", 64'(fill_valid), 64'd0);
        tick(); idle();
        tick(); idle();

        // Alloc matching an in-flight fill
        alloc(32'h0000_3000); #1;
        chk("t5_gnt", 64'(alloc_gnt), 64'd1);
        tick(); idle(); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd2;
        tick(); idle(); alloc(32'h0000_3000); data(4'd2, 64'h3333_3333_3333_3333); #1;
        expect_fill(2'd0, 32'h3000, 64'h3333_3333_3333_3333);
        chk("t5_refused", 64'(alloc_gnt), 64'd0);
        tick(); idle(); #1;
        chk("t5_fill_still", 64'(fill_valid), 64'd1);
        tick(); idle();

        // Asynchronous reset with two entries waiting
        alloc(32'h0000_7000);
        tick(); idle(); alloc(32'h0000_7008); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd10; #1;
        chk("t6_idx1", 64'(alloc_idx), 64'd1);
        tick(); idle(); alloc(32'h0000_7010); mem_gnt = 1'b1; mem2proc_transaction_tag = 4'd11; #1;
        chk("t6_idx2", 64'(alloc_idx), 64'd2);
        tick(); idle();
        chk("t6_pre_cmd", 64'(proc2mem_command), 64'd1);
        chk("t6_pre_addr", 64'(proc2mem_addr), 64'h7010);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_cmd", 64'(proc2mem_command), 64'd0);
        chk("t6_async_addr", 64'(proc2mem_addr), 64'd0);
        chk("t6_async_full", 64'(mshr_full), 64'd0);
        chk("t6_async_fill", 64'(fill_valid), 64'd0);
        #1 reset = 1'b1;
        tick(); idle(); data(4'd10, 64'hDEAD_BEEF_0000_0010);
        tick(); idle(); data(4'd11, 64'hDEAD_BEEF_0000_0011); #1;
        chk("t6_late_tag10", 64'(fill_valid), 64'd0);
        tick(); idle(); alloc(32'h0000_7008); #1;
        chk("t6_late_tag11", 64'(fill_valid), 64'd0);
        chk("t6_realloc_idx", 64'(alloc_idx), 64'd0);
        chk("t6_realloc_merge", 64'(alloc_merge), 64'd0);
        tick(); idle();
        tick(); idle();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
